// File: rtl/pattern_sig_unit.sv
// Exhaustive 4-input pattern generator with a 16-bit MISR response compactor.
// Optional 1-bit response population counter enabled by PATTERN_SIG_ONES_COUNT_EN.
module pattern_sig_unit #(
  parameter logic [15:0] SEED = 16'hFFFF,
  parameter int          NPAT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        x0,
  output logic        x1,
  output logic        x2,
  output logic        x3,
  input  logic        f1,
  input  logic        f2,
  input  logic        f3,
  input  logic        f4,
  input  logic        f5,
  input  logic        f6,
  input  logic        f7,
  input  logic        f8,
  input  logic        f9,
  input  logic        f10,
  input  logic        f11,
  output logic        busy,
  output logic [15:0] sig,
  output logic        sig_valid,
  input  logic        sig_ready,
  output logic [7:0]  ones_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST = 4'(NPAT - 1);

  state_t      r_state;
  logic [3:0]  r_pat;
  logic [15:0] r_misr;
  logic        r_busy;
  logic        r_sig_valid;

  logic [10:0] w_resp;
  logic [15:0] w_misr_nxt;

  assign w_resp     = {f11, f10, f9, f8, f7, f6, f5, f4, f3, f2, f1};
  assign w_misr_nxt = {r_misr[14:0], 1'b0} ^ (r_misr[15] ? 16'h1021 : 16'h0000)
                    ^ {5'b0, w_resp};

  // r_pat is forced back to 0 whenever RUN is left, so it doubles as the x register.
  assign {x3, x2, x1, x0} = r_pat;
  assign busy             = r_busy;
  assign sig              = r_misr;
  assign sig_valid        = r_sig_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pat       <= 4'd0;
      r_misr      <= 16'h0000;
      r_busy      <= 1'b0;
      r_sig_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_misr  <= SEED;
            r_pat   <= 4'd0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            r_state <= IDLE;
            r_pat   <= 4'd0;
            r_busy  <= 1'b0;
          end else begin
            r_misr <= w_misr_nxt;
            if (r_pat == LAST) begin
              r_state     <= DONE;
              r_pat       <= 4'd0;
              r_busy      <= 1'b0;
              r_sig_valid <= 1'b1;
            end else begin
              r_pat <= r_pat + 4'd1;
            end
          end
        end
        DONE: begin
          if (sig_ready) begin
            r_state     <= IDLE;
            r_sig_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_pat   <= 4'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PATTERN_SIG_ONES_COUNT_EN
  logic [7:0] r_ones;
  logic [3:0] w_pop;
  logic [8:0] w_sum;

  assign w_pop    = 4'($countones(w_resp));
  assign w_sum    = {1'b0, r_ones} + {5'b0, w_pop};
  assign ones_cnt = r_ones;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ones <= 8'd0;
    end else if (r_state == IDLE && start) begin
      r_ones <= 8'd0;
    end else if (r_state == RUN && !abort) begin
      r_ones <= w_sum[8] ? 8'hFF : w_sum[7:0];
    end
  end
`else
  assign ones_cnt = 8'd0;
`endif

endmodule
